// File: rtl/apb_cmd_master.sv
// Converts a valid/ready command stream into APB3 SETUP/ACCESS transfers and returns a one-cycle response.
// Latency: command accepted at edge k gives SETUP in k+1, ACCESS from k+2, rsp_valid one cycle after the final ACCESS.
// Backpressure: cmd_ready drops while the one-entry hold register is occupied; responses cannot be stalled.
//
// Ports:
//   PCLK, PRESETn              clock; synchronous reset, active-high despite the name
//   cmd_valid/ready/write/addr/wdata   command stream in
//   rsp_valid/rdata/err        response pulse out (rdata is 0 for writes and timeouts)
//   PSEL/PENABLE/PWrite/PADDR/PWDATA   APB requester outputs
//   PRDATA/PREADY              APB completer inputs
module apb_cmd_master #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWrite,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);

    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                hold_full_q, hold_full_d;
    logic                hold_write_q, hold_write_d;
    logic [ADDR_W-1:0]   hold_addr_q, hold_addr_d;
    logic [DATA_W-1:0]   hold_wdata_q, hold_wdata_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;

    logic accept;
    logic at_limit;
    logic xfer_end;
    logic timed_out;

    assign cmd_ready = !hold_full_q && !PRESETn;
    assign accept    = cmd_valid && cmd_ready;
    assign at_limit  = (wait_cnt_q == CNT_MAX);
    // A transfer ends either on PREADY or after TIMEOUT+1 ACCESS cycles of waiting.
    assign xfer_end  = (state_q == S_ACCESS) && (PREADY || at_limit);
    assign timed_out = (state_q == S_ACCESS) && !PREADY && at_limit;

    // State register (also holds all datapath flops)
    always_ff @(posedge PCLK) begin
        if (PRESETn) begin
            state_q      <= S_IDLE;
            hold_full_q  <= 1'b0;
            hold_write_q <= 1'b0;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            wait_cnt_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            hold_full_q  <= hold_full_d;
            hold_write_q <= hold_write_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            wait_cnt_q   <= wait_cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_rdata_q  <= rsp_rdata_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (accept) state_d = S_SETUP;
            S_SETUP:  state_d = S_ACCESS;
            S_ACCESS: begin
                // Chain straight into the next SETUP when work is waiting, keeping PSEL high.
                if (xfer_end) state_d = (hold_full_q || accept) ? S_SETUP : S_IDLE;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath: APB address/data registers, hold register, wait counter, response
    always_comb begin
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        hold_full_d  = hold_full_q;
        hold_write_d = hold_write_q;
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;
        wait_cnt_d   = wait_cnt_q;
        rsp_valid_d  = 1'b0;
        rsp_err_d    = 1'b0;
        rsp_rdata_d  = '0;

        // Every ACCESS is preceded by exactly one SETUP, so clearing here clears on ACCESS entry.
        if (state_q == S_SETUP) begin
            wait_cnt_d = '0;
        end else if ((state_q == S_ACCESS) && !PREADY && !at_limit) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end

        if (xfer_end) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = timed_out;
            if (!timed_out && !pwrite_q) rsp_rdata_d = PRDATA;
        end

        // cmd_ready is low while hold is full, so a held command and a new acceptance never coincide.
        if (xfer_end && hold_full_q) begin
            pwrite_d    = hold_write_q;
            paddr_d     = hold_addr_q;
            pwdata_d    = hold_wdata_q;
            hold_full_d = 1'b0;
        end else if (accept) begin
            if ((state_q == S_IDLE) || xfer_end) begin
                pwrite_d = cmd_write;
                paddr_d  = cmd_addr;
                pwdata_d = cmd_wdata;
            end else begin
                hold_write_d = cmd_write;
                hold_addr_d  = cmd_addr;
                hold_wdata_d = cmd_wdata;
                hold_full_d  = 1'b1;
            end
        end
    end

    // Output logic
    always_comb begin
        PSEL    = (state_q != S_IDLE);
        PENABLE = (state_q == S_ACCESS);
    end

    assign PWrite    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master: vector table, hand-written corner sequences, random run vs. transaction model.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled 3 units after it.
// The summary line reports comparisons made and comparisons failed.
module tb_apb_cmd_master;
    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 15;

    logic              PCLK = 1'b0;
    logic              PRESETn;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              PSEL;
    logic              PENABLE;
    logic              PWrite;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;

    apb_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWrite(PWrite), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 PCLK = ~PCLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    typedef struct {
        logic       rst, valid, write;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic       pready;
        logic [7:0] prdata;
        logic       e_psel, e_pen, e_pwrite;
        logic [3:0] e_paddr;
        logic [7:0] e_pwdata;
        logic       e_rv, e_err;
        logic [7:0] e_rdata;
        logic       e_ready;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic valid, input logic write,
                                input logic [3:0] addr, input logic [7:0] wdata,
                                input logic pready, input logic [7:0] prdata,
                                input logic ep, input logic een, input logic ew,
                                input logic [3:0] ea, input logic [7:0] ed,
                                input logic erv, input logic eerr, input logic [7:0] erd,
                                input logic erdy);
        vec_t v;
        v.rst = rst; v.valid = valid; v.write = write; v.addr = addr; v.wdata = wdata;
        v.pready = pready; v.prdata = prdata;
        v.e_psel = ep; v.e_pen = een; v.e_pwrite = ew; v.e_paddr = ea; v.e_pwdata = ed;
        v.e_rv = erv; v.e_err = eerr; v.e_rdata = erd; v.e_ready = erdy;
        return v;
    endfunction

    typedef struct {
        logic       w;
        logic [3:0] a;
        logic [7:0] d;
    } cmd_t;

    // Transaction-level reference model state
    cmd_t       pend_q[$];
    cmd_t       cur;
    bit         active;
    int         age;       // 0 = setup cycle, n >= 1 = n-th access cycle
    logic       m_rv, m_err;
    logic [7:0] m_rdata;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vt[16];
        int   n_acc;
        bit   seen;

        // reset(3) -> idle -> zero-wait write -> back-to-back writes
        vt[0]  = mk(1'b1,1'b1,1'b1,4'h4,8'hA5,1'b1,8'h00, 1'b0,1'b0,1'b0,4'h0,8'h00,1'b0,1'b0,8'h00,1'b0);
        vt[1]  = vt[0];
        vt[2]  = vt[0];
        vt[3]  = mk(1'b0,1'b0,1'b0,4'h0,8'h00,1'b1,8'h00, 1'b0,1'b0,1'b0,4'h0,8'h00,1'b0,1'b0,8'h00,1'b1);
        vt[4]  = vt[3];
        vt[5]  = mk(1'b0,1'b1,1'b1,4'h4,8'hA5,1'b1,8'h00, 1'b0,1'b0,1'b0,4'h0,8'h00,1'b0,1'b0,8'h00,1'b1);
        vt[6]  = mk(1'b0,1'b0,1'b0,4'h0,8'h00,1'b1,8'h00, 1'b1,1'b0,1'b1,4'h4,8'hA5,1'b0,1'b0,8'h00,1'b1);
        vt[7]  = mk(1'b0,1'b0,1'b0,4'h0,8'h00,1'b1,8'h5A, 1'b1,1'b1,1'b1,4'h4,8'hA5,1'b0,1'b0,8'h00,1'b1);
        vt[8]  = mk(1'b0,1'b0,1'b0,4'h0,8'h00,1'b1,8'h00, 1'b0,1'b0,1'b1,4'h4,8'hA5,1'b1,1'b0,8'h00,1'b1);
        vt[9]  = mk(1'b0,1'b1,1'b1,4'h8,8'h0F,1'b1,8'h00, 1'b0,1'b0,1'b1,4'h4,8'hA5,1'b0,1'b0,8'h00,1'b1);
        vt[10] = mk(1'b0,1'b1,1'b1,4'hC,8'hF0,1'b1,8'h00, 1'b1,1'b0,1'b1,4'h8,8'h0F,1'b0,1'b0,8'h00,1'b1);
        vt[11] = mk(1'b0,1'b0,1'b0,4'h0,8'h00,1'b1,8'h33, 1'b1,1'b1,1'b1,4'h8,8'h0F,1'b0,1'b0,8'h00,1'b0);
        vt[12] = mk(1'b0,1'b0,1'b0,4'h0,8'h00,1'b1,8'h00, 1'b1,1'b0,1'b1,4'hC,8'hF0,1'b1,1'b0,8'h00,1'b1);
        vt[13] = mk(1'b0,1'b0,1'b0,4'h0,8'h00,1'b1,8'h33, 1'b1,1'b1,1'b1,4'hC,8'hF0,1'b0,1'b0,8'h00,1'b1);
        vt[14] = mk(1'b0,1'b0,1'b0,4'h0,8'h00,1'b1,8'h00, 1'b0,1'b0,1'b1,4'hC,8'hF0,1'b1,1'b0,8'h00,1'b1);
        vt[15] = mk(1'b0,1'b0,1'b0,4'h0,8'h00,1'b1,8'h00, 1'b0,1'b0,1'b1,4'hC,8'hF0,1'b0,1'b0,8'h00,1'b1);

        PRESETn = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h4; cmd_wdata = 8'hA5;
        PREADY = 1'b1; PRDATA = 8'h00;
        step();

        for (int i = 0; i < 16; i++) begin
            PRESETn = vt[i].rst; cmd_valid = vt[i].valid; cmd_write = vt[i].write;
            cmd_addr = vt[i].addr; cmd_wdata = vt[i].wdata;
            PREADY = vt[i].pready; PRDATA = vt[i].prdata;
            #2;
            chk($sformatf("row%0d_psel", i),    32'(PSEL),      32'(vt[i].e_psel));
            chk($sformatf("row%0d_penable", i), 32'(PENABLE),   32'(vt[i].e_pen));
            chk($sformatf("row%0d_pwrite", i),  32'(PWrite),    32'(vt[i].e_pwrite));
            chk($sformatf("row%0d_paddr", i),   32'(PADDR),     32'(vt[i].e_paddr));
            chk($sformatf("row%0d_pwdata", i),  32'(PWDATA),    32'(vt[i].e_pwdata));
            chk($sformatf("row%0d_rsp_valid", i), 32'(rsp_valid), 32'(vt[i].e_rv));
            chk($sformatf("row%0d_rsp_err", i), 32'(rsp_err),   32'(vt[i].e_err));
            chk($sformatf("row%0d_rsp_rdata", i), 32'(rsp_rdata), 32'(vt[i].e_rdata));
            chk($sformatf("row%0d_cmd_ready", i), 32'(cmd_ready), 32'(vt[i].e_ready));
            step();
        end

        // Read with 3 wait states; PRDATA is garbage except on the completing edge.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h0; cmd_wdata = 8'h00;
        PREADY = 1'b0; PRDATA = 8'h55;
        step();
        cmd_valid = 1'b0;
        #2;
        chk("rd_setup_psel", 32'(PSEL), 32'd1);
        chk("rd_setup_penable", 32'(PENABLE), 32'd0);
        chk("rd_setup_pwrite", 32'(PWrite), 32'd0);
        chk("rd_setup_paddr", 32'(PADDR), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(); #2;
            chk($sformatf("rd_wait%0d_penable", i), 32'(PENABLE), 32'd1);
            chk($sformatf("rd_wait%0d_rsp_valid", i), 32'(rsp_valid), 32'd0);
        end
        step();
        PREADY = 1'b1; PRDATA = 8'h3C;
        #2;
        chk("rd_last_penable", 32'(PENABLE), 32'd1);
        step();
        PREADY = 1'b0; PRDATA = 8'h55;
        #2;
        chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rd_rsp_rdata", 32'(rsp_rdata), 32'h3C);
        chk("rd_rsp_err", 32'(rsp_err), 32'd0);
        chk("rd_rsp_psel", 32'(PSEL), 32'd0);
        step(); #2;
        chk("rd_rsp_one_cycle", 32'(rsp_valid), 32'd0);

        // Timeout on a read, with a write queued behind it.
        step();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h2; PREADY = 1'b0;
        step();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h5; cmd_wdata = 8'h77;
        step();
        cmd_valid = 1'b0;
        #2;
        chk("to_hold_ready", 32'(cmd_ready), 32'd0);
        n_acc = 0; seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
            if (PSEL && PENABLE) n_acc++;
            step(); #2;
        end
        chk("to_rsp_seen", 32'(seen), 32'd1);
        chk("to_access_cycles", 32'(n_acc), 32'(TIMEOUT + 1));
        chk("to_rsp_err", 32'(rsp_err), 32'd1);
        chk("to_rsp_rdata", 32'(rsp_rdata), 32'h0);
        chk("to_next_psel", 32'(PSEL), 32'd1);
        chk("to_next_penable", 32'(PENABLE), 32'd0);
        chk("to_next_paddr", 32'(PADDR), 32'h5);
        chk("to_next_pwdata", 32'(PWDATA), 32'h77);
        chk("to_next_pwrite", 32'(PWrite), 32'd1);
        PREADY = 1'b1;
        step(); #2;
        chk("to_next_access", 32'(PENABLE), 32'd1);
        step(); #2;
        chk("to_next_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("to_next_rsp_err", 32'(rsp_err), 32'd0);

        // Reset in the 2nd ACCESS cycle of a wait-stated read, with a write held.
        step();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h3; PREADY = 1'b0;
        step();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h9; cmd_wdata = 8'h99;
        step();
        cmd_valid = 1'b0;
        step();
        PRESETn = 1'b1;
        #2;
        chk("rst_mid_penable", 32'(PENABLE), 32'd1);
        chk("rst_mid_ready", 32'(cmd_ready), 32'd0);
        step();
        PRESETn = 1'b0; PREADY = 1'b1;
        #2;
        chk("rst_after_psel", 32'(PSEL), 32'd0);
        chk("rst_after_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_after_paddr", 32'(PADDR), 32'h0);
        for (int i = 0; i < 6; i++) begin
            step(); #2;
            chk($sformatf("rst_drop%0d_psel", i), 32'(PSEL), 32'd0);
            chk($sformatf("rst_drop%0d_rsp_valid", i), 32'(rsp_valid), 32'd0);
        end

        // Random traffic against the transaction model.
        step();
        PRESETn = 1'b1;
        step();
        step();
        PRESETn = 1'b0;
        pend_q.delete();
        cur = '{w: 1'b0, a: 4'h0, d: 8'h00};
        active = 1'b0; age = 0;
        m_rv = 1'b0; m_err = 1'b0; m_rdata = 8'h00;
        for (int i = 0; i < 800; i++) begin
            int   lowpct;
            bit   ready_e, acc, fin;
            cmd_t c;
            lowpct = (i < 300) ? 30 : ((i < 550) ? 92 : 50);
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_write = 1'($urandom_range(0, 1));
            cmd_addr  = 4'($urandom);
            cmd_wdata = 8'($urandom);
            PREADY    = ($urandom_range(0, 99) >= lowpct);
            PRDATA    = 8'($urandom);
            #2;
            ready_e = (pend_q.size() == 0);
            chk("rnd_psel", 32'(PSEL), 32'(active));
            chk("rnd_penable", 32'(PENABLE), 32'(active && age >= 1));
            chk("rnd_pwrite", 32'(PWrite), 32'(cur.w));
            chk("rnd_paddr", 32'(PADDR), 32'(cur.a));
            chk("rnd_pwdata", 32'(PWDATA), 32'(cur.d));
            chk("rnd_rsp_valid", 32'(rsp_valid), 32'(m_rv));
            chk("rnd_rsp_err", 32'(rsp_err), 32'(m_err));
            chk("rnd_rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
            chk("rnd_cmd_ready", 32'(cmd_ready), 32'(ready_e));

            acc = cmd_valid && ready_e;
            fin = active && (age >= 1) && (PREADY || (age == TIMEOUT + 1));
            m_rv    = fin;
            m_err   = fin && !PREADY;
            m_rdata = (fin && PREADY && !cur.w) ? PRDATA : 8'h00;
            if (acc) begin
                c.w = cmd_write; c.a = cmd_addr; c.d = cmd_wdata;
                pend_q.push_back(c);
            end
            if (!active || fin) begin
                if (pend_q.size() > 0) begin
                    cur = pend_q.pop_front();
                    active = 1'b1;
                    age = 0;
                end else begin
                    active = 1'b0;
                end
            end else begin
                age++;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/apb_cmd_master.md
# apb_cmd_master

Upstream APB requester for the GPIO peripheral. It converts a simple valid/ready command stream from the processor-side logic into APB3 SETUP/ACCESS transfers, and drives the peripheral's PSEL/PENABLE/PADDR/PWDATA/PWrite. It returns read data or a timeout error as a one-cycle response pulse. A one-entry holding register lets a new command be queued while a transfer is in flight, so transfers can run back-to-back.

## Interface
Parameters:
- ADDR_W, 4, width of cmd_addr and PADDR
- DATA_W, 8, width of write/read data
- TIMEOUT, 15, number of PREADY-low ACCESS cycles tolerated before abort; legal range is 1 or more

Ports:
- PCLK  in  1  single clock; all logic is on the rising edge
- PRESETn  in  1  reset; synchronous, active-high (asserted when 1)
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command can be accepted
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target register address
- cmd_wdata  in  DATA_W  write data; ignored for reads
- rsp_valid  out  1  one-cycle pulse, transfer finished
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  transfer aborted on timeout; qualified by rsp_valid
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWrite  out  1  APB direction
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  APB ready; tie to 1 for zero-wait slaves

## Operation
- **States.** IDLE (PSEL=0, PENABLE=0), SETUP (PSEL=1, PENABLE=0), ACCESS (PSEL=1, PENABLE=1).
- **Handshake.** A command is accepted on a clock edge where cmd_valid && cmd_ready. cmd_ready = !hold_full && !PRESETn. No response backpressure.
- **Acceptance in IDLE.** The command loads directly into PADDR/PWDATA/PWrite. The next state is SETUP.
- **Acceptance while busy** (SETUP or ACCESS):
  - If the current transfer completes on the same edge, the command loads directly into the APB registers and the next state is SETUP.
  - Otherwise the command goes into the hold register and hold_full is set.
- **SETUP → ACCESS** unconditionally after one cycle.
- **ACCESS, PREADY=1.** The transfer completes:
  - rsp_rdata is set to PRDATA for reads, 0 for writes; rsp_err=0.
  - Next state is SETUP if the hold register is full (hold is moved to the APB registers and hold_full cleared) or a command is accepted that edge. Otherwise next state is IDLE.
- **ACCESS, PREADY=0.**
  - If wait_cnt==TIMEOUT: abort with rsp_err=1, rsp_rdata=0. The next-state rule is the same as for completion.
  - Otherwise wait_cnt increments.
  - wait_cnt clears on entry to ACCESS.
- **Signal stability.** PADDR, PWDATA and PWrite are stable from SETUP through the final ACCESS cycle. In IDLE they hold their last values.
- **Counter width.** wait_cnt is $clog2(TIMEOUT+1) bits and never wraps.
- **Reset** (PRESETn=1 at an edge):
  - State goes to IDLE and hold_full to 0.
  - All outputs go to 0: PSEL, PENABLE, PWrite, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err.
  - cmd_ready is 0 while reset is asserted, and 1 in the first cycle after release.
  - A transfer in flight, including one in mid-ACCESS, is dropped with no response. A held command is discarded.

## Timing
- **Zero-wait latency.** Command accepted at edge k: SETUP in cycle k+1, ACCESS in cycle k+2, completion at the end of cycle k+2. rsp_valid is high for exactly cycle k+3.
- **Wait states.** Each PREADY-low ACCESS cycle adds 1 cycle of latency. The maximum ACCESS length is TIMEOUT+1 cycles.
- **Back-to-back throughput.** With the hold register full, 2 cycles per transfer (ACCESS→SETUP directly, no IDLE cycle). PSEL stays high across the boundary; PENABLE drops for the SETUP cycle.
- **Response vs. next SETUP.** rsp_valid for transfer N coincides with the SETUP cycle of transfer N+1.
- **Read capture.** PRDATA is sampled only on the completing ACCESS edge.

## Test plan
- **Reset.** Hold PRESETn=1 for 3 cycles with cmd_valid=1.
  - During reset: all outputs 0 and cmd_ready=0.
  - After release: cmd_ready=1 and no transfer starts until a command is accepted after release.
- **Zero-wait write.** PREADY=1; write addr 4'h4, data 8'hA5.
  - Cycle k+1: PSEL=1, PENABLE=0. Cycle k+2: PSEL=1, PENABLE=1, PADDR=4, PWDATA=A5, PWrite=1.
  - Cycle k+3: rsp_valid=1, rsp_err=0, rsp_rdata=0, PSEL=0.
- **Read with wait states.** Read addr 4'h0; PREADY low for 3 ACCESS cycles, then high with PRDATA=8'h3C.
  - ACCESS lasts 4 cycles.
  - rsp_valid rises at k+6 with rsp_rdata=3C, and is high for one cycle only.
- **Back-to-back.** Present writes (8, 8'h0F) then (C, 8'hF0) on consecutive cycles with PREADY=1.
  - The second command is accepted into hold while the first is in SETUP.
  - Trace: SETUP/ACCESS/SETUP/ACCESS with no IDLE gap. Two rsp_valid pulses 2 cycles apart.
  - cmd_ready is 0 while hold is full.
- **Timeout.** TIMEOUT=15, PREADY held 0 on a read.
  - Exactly 16 ACCESS cycles, then rsp_valid=1, rsp_err=1, rsp_rdata=0.
  - The next queued command starts normally.
- **Reset mid-transfer.** Assert PRESETn in the 2nd ACCESS cycle of a wait-stated transfer, with hold full.
  - Next cycle: PSEL=0 and no rsp_valid.
  - The held command is never issued.
